// File: rtl/ct_vfalu_ex3_wb_buf.sv
// ct_vfalu_ex3_wb_buf: queues merged vfalu ex3 results and drains them to the FP register-file write port
module ct_vfalu_ex3_wb_buf #(
    parameter int DEPTH  = 4,
    parameter int PREG_W = 7,
    parameter int SKID   = 2
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    input  logic              rtu_yy_xx_flush,
    input  logic              ex3_vfalu_res_vld,
    input  logic [63:0]       ex3_vfalu_freg_data,
    input  logic [4:0]        ex3_vfalu_ereg_data,
    input  logic [PREG_W-1:0] ex3_vfalu_dst_preg,
    input  logic              rf_wb_grant,
    input  logic              fflags_clr,
    output logic              wb_vfalu_vld,
    output logic [63:0]       wb_vfalu_data,
    output logic [PREG_W-1:0] wb_vfalu_preg,
    output logic [4:0]        wb_vfalu_fflags,
    output logic              vfalu_wb_stall,
    output logic              vfalu_wb_ovfl
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - 1 - SKID);

    logic [63:0]       data_mem [DEPTH];
    logic [PREG_W-1:0] preg_mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW:0]       count, count_next;
    logic              full, push, pop;

    assign wb_vfalu_vld  = count != '0;
    assign wb_vfalu_data = data_mem[rd_ptr];
    assign wb_vfalu_preg = preg_mem[rd_ptr];

    // push/pop decisions; a pop frees the slot for a same-cycle push when full
    always_comb begin
        full       = count == FULL;
        pop        = wb_vfalu_vld & rf_wb_grant & ~rtu_yy_xx_flush;
        push       = ex3_vfalu_res_vld & ~rtu_yy_xx_flush & (~full | pop);
        count_next = rtu_yy_xx_flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
    end

    // entry storage, deliberately unreset
    always_ff @(posedge forever_cpuclk) begin
        if (push) begin
            data_mem[wr_ptr] <= ex3_vfalu_freg_data;
            preg_mem[wr_ptr] <= ex3_vfalu_dst_preg;
        end
    end

    // pointers, occupancy and early stall to protect ex1/ex2 in-flight ops
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            vfalu_wb_stall <= 1'b0;
        end else begin
            rd_ptr         <= rtu_yy_xx_flush ? '0 : rd_ptr + AW'(pop);
            wr_ptr         <= rtu_yy_xx_flush ? '0 : wr_ptr + AW'(push);
            count          <= count_next;
            vfalu_wb_stall <= count_next > STALL_TH;
        end
    end

    // sticky fflags accumulator; a push in the clear cycle survives the clear
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst)
            wb_vfalu_fflags <= '0;
        else if (push)
            wb_vfalu_fflags <= fflags_clr ? ex3_vfalu_ereg_data : wb_vfalu_fflags | ex3_vfalu_ereg_data;
        else if (fflags_clr)
            wb_vfalu_fflags <= '0;
    end

    // sticky overflow: result arrived with no free slot and no draining pop
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst)
            vfalu_wb_ovfl <= 1'b0;
        else if (ex3_vfalu_res_vld & ~rtu_yy_xx_flush & full & ~pop)
            vfalu_wb_ovfl <= 1'b1;
    end
endmodule

// File: tb/tb_ct_vfalu_ex3_wb_buf.sv
// tb_ct_vfalu_ex3_wb_buf: scoreboard bench for the vfalu ex3 write-back buffer
module tb_ct_vfalu_ex3_wb_buf;
    typedef struct packed {
        logic [63:0] d;
        logic [6:0]  p;
    } ent_t;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, res_vld = 1'b0, grant = 1'b0, clr = 1'b0;
    logic [63:0] fdata = '0;
    logic [4:0]  ereg = '0;
    logic [6:0]  preg = '0;
    logic        wb_vld, wb_stall, wb_ovfl;
    logic [63:0] wb_data;
    logic [6:0]  wb_preg;
    logic [4:0]  wb_fflags;

    ent_t q[$];
    int   n_chk = 0, n_pass = 0;

    ct_vfalu_ex3_wb_buf #(.DEPTH(4), .PREG_W(7), .SKID(2)) dut (
        .forever_cpuclk      (clk),
        .cpurst              (rst),
        .rtu_yy_xx_flush     (flush),
        .ex3_vfalu_res_vld   (res_vld),
        .ex3_vfalu_freg_data (fdata),
        .ex3_vfalu_ereg_data (ereg),
        .ex3_vfalu_dst_preg  (preg),
        .rf_wb_grant         (grant),
        .fflags_clr          (clr),
        .wb_vfalu_vld        (wb_vld),
        .wb_vfalu_data       (wb_data),
        .wb_vfalu_preg       (wb_preg),
        .wb_vfalu_fflags     (wb_fflags),
        .vfalu_wb_stall      (wb_stall),
        .vfalu_wb_ovfl       (wb_ovfl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // one cycle of stimulus; accepted pushes go to the scoreboard, a flush empties it
    task automatic cyc(input logic v, input logic [63:0] dat, input logic [6:0] pr, input logic [4:0] e,
                       input logic g, input logic f, input logic c, input logic acc);
        res_vld = v; fdata = dat; preg = pr; ereg = e; grant = g; flush = f; clr = c;
        if (acc) q.push_back(ent_t'{dat, pr});
        @(posedge clk); #1;
        if (f) q.delete();
        res_vld = 1'b0; grant = 1'b0; flush = 1'b0; clr = 1'b0;
    endtask

    // monitor: head must match the oldest expected result; a granted write retires it
    always @(negedge clk) begin
        if (!rst && wb_vld) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL wb_unexpected actual=vld1 required=no_write");
            end else begin
                chk("wb_data", wb_data, q[0].d);
                chk("wb_preg", 64'(wb_preg), 64'(q[0].p));
                if (grant && !flush) void'(q.pop_front());
            end
        end
    end

    initial begin
        int k;
        #2;
        chk("rst_vld", 64'(wb_vld), 64'd0);
        chk("rst_stall", 64'(wb_stall), 64'd0);
        chk("rst_fflags", 64'(wb_fflags), 64'd0);
        chk("rst_ovfl", 64'(wb_ovfl), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // single pass-through with grant held high
        cyc(1, 64'h3FF0_0000_0000_0000, 7'd12, 5'b00001, 1, 0, 0, 1);
        chk("pt_vld", 64'(wb_vld), 64'd1);
        chk("pt_data", wb_data, 64'h3FF0_0000_0000_0000);
        chk("pt_preg", 64'(wb_preg), 64'd12);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("pt_vld_off", 64'(wb_vld), 64'd0);
        chk("pt_fflags", 64'(wb_fflags), 64'h01);

        // full with simultaneous push and pop
        for (int i = 0; i < 4; i++) cyc(1, 64'hA000 + 64'(i), 7'(20 + i), 0, 0, 0, 0, 1);
        chk("full_stall", 64'(wb_stall), 64'd1);
        cyc(1, 64'hA004, 7'd24, 0, 1, 0, 0, 1);
        chk("fpp_ovfl", 64'(wb_ovfl), 64'd0);
        chk("fpp_vld", 64'(wb_vld), 64'd1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("fpp_empty", 64'(wb_vld), 64'd0);

        // pointer wrap, occupancy alternating between 1 and 3
        k = 0;
        cyc(1, 64'hB000 + 64'(k), 7'(k), 0, 0, 0, 0, 1); k++;
        for (int j = 0; j < 6; j++) begin
            cyc(1, 64'hB000 + 64'(k), 7'(k), 0, 0, 0, 0, 1); k++;
            cyc(1, 64'hB000 + 64'(k), 7'(k), 0, 0, 0, 0, 1); k++;
            chk("wrap_stall", 64'(wb_stall), 64'd1);
            chk("wrap_vld_a", 64'(wb_vld), 64'd1);
            cyc(0, 0, 0, 0, 1, 0, 0, 0);
            chk("wrap_vld_b", 64'(wb_vld), 64'd1);
            cyc(0, 0, 0, 0, 1, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("wrap_empty", 64'(wb_vld), 64'd0);

        // fill to full then overflow
        cyc(1, 64'hC000, 7'd40, 0, 0, 0, 0, 1);
        chk("ov_stall1", 64'(wb_stall), 64'd0);
        cyc(1, 64'hC001, 7'd41, 0, 0, 0, 0, 1);
        chk("ov_stall2", 64'(wb_stall), 64'd1);
        cyc(1, 64'hC002, 7'd42, 0, 0, 0, 0, 1);
        cyc(1, 64'hC003, 7'd43, 0, 0, 0, 0, 1);
        chk("ov_pre", 64'(wb_ovfl), 64'd0);
        cyc(1, 64'hC004, 7'd44, 5'b11111, 0, 0, 0, 0);
        chk("ov_set", 64'(wb_ovfl), 64'd1);
        chk("ov_fflags", 64'(wb_fflags), 64'h01);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("ov_empty", 64'(wb_vld), 64'd0);
        chk("ov_stall_off", 64'(wb_stall), 64'd0);
        chk("ov_sticky", 64'(wb_ovfl), 64'd1);

        // asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) cyc(1, 64'hD000 + 64'(i), 7'(50 + i), 5'b01000, 0, 0, 0, 1);
        #1 rst = 1'b1;
        #1;
        chk("ar_vld", 64'(wb_vld), 64'd0);
        chk("ar_stall", 64'(wb_stall), 64'd0);
        chk("ar_fflags", 64'(wb_fflags), 64'd0);
        chk("ar_ovfl", 64'(wb_ovfl), 64'd0);
        q.delete();
        #1 rst = 1'b0;
        @(posedge clk); #1;
        cyc(1, 64'hE000_0000_1234_5678, 7'd60, 5'b00010, 0, 0, 0, 1);
        chk("ar_push_vld", 64'(wb_vld), 64'd1);
        chk("ar_push_data", wb_data, 64'hE000_0000_1234_5678);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);

        // flush with a push and grant, then clear combined with a push
        cyc(1, 64'hF000, 7'd70, 0, 0, 0, 0, 1);
        cyc(1, 64'hF001, 7'd71, 0, 0, 0, 0, 1);
        cyc(1, 64'hF002, 7'd72, 5'b10000, 1, 1, 0, 0);
        chk("fl_vld", 64'(wb_vld), 64'd0);
        chk("fl_stall", 64'(wb_stall), 64'd0);
        chk("fl_fflags", 64'(wb_fflags), 64'h02);
        cyc(1, 64'hF003, 7'd73, 5'b00100, 0, 0, 1, 1);
        chk("clr_push_fflags", 64'(wb_fflags), 64'h04);
        chk("clr_push_vld", 64'(wb_vld), 64'd1);
        cyc(0, 0, 0, 0, 1, 0, 1, 0);
        chk("clr_fflags", 64'(wb_fflags), 64'd0);

        // bounded final drain
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("drain_left", 64'(q.size()), 64'd0);
        chk("drain_vld", 64'(wb_vld), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
